// File: rtl/softsign_denom_array.sv
// softsign_denom_array: computes 1+|x| (or a selected variant) for CHANNELS
// signed neuron sums per transaction. One saturating datapath is shared and
// time-multiplexed, one channel per clock. The startout pulse launches the
// downstream softsign divider.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; denom/sat hold the last transaction's results
// CALC  | one channel per clock from the captured snapshot; idx = channel
// DONE  | one-cycle startout pulse, then back to IDLE
module softsign_denom_array #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int OFFSET   = 1
) (
    input  logic                      CLOCK,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic [CHANNELS*WIDTH-1:0] X,
    output logic [CHANNELS*WIDTH-1:0] denom,
    output logic [CHANNELS-1:0]       sat,
    output logic                      busy,
    output logic                      startout
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // All arithmetic is done one bit wider so |-2^(WIDTH-1)| and |x|+OFFSET
    // are representable before the saturation compare.
    localparam logic signed [WIDTH:0] MAX_EXT = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0] OFF_EXT = (WIDTH+1)'(OFFSET);
    localparam logic signed [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0]      MAX_OUT = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [IDX_W-1:0]          idx;
    logic [CHANNELS*WIDTH-1:0] x_snap;
    logic [1:0]                mode_snap;
    logic [CHANNELS*WIDTH-1:0] work_buf;
    logic [CHANNELS*WIDTH-1:0] work_nxt;
    logic [CHANNELS-1:0]       work_sat;
    logic [CHANNELS-1:0]       work_sat_nxt;

    logic [WIDTH-1:0]          ch_x;
    logic [WIDTH-1:0]          ch_res;
    logic                      ch_sat;
    logic signed [WIDTH:0]     x_ext;
    logic signed [WIDTH:0]     abs_ext;
    logic signed [WIDTH:0]     r_ext;
    logic                      last;

    assign last = (idx == LAST_IDX);

    // Select the snapshot channel addressed by idx.
    always_comb begin
        ch_x = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx == IDX_W'(i)) begin
                ch_x = x_snap[i*WIDTH +: WIDTH];
            end
        end
    end

    // Shared saturating datapath: variant select, then clamp to MAX.
    always_comb begin
        x_ext   = {ch_x[WIDTH-1], ch_x};
        abs_ext = ch_x[WIDTH-1] ? (~x_ext + ONE_EXT) : x_ext;
        case (mode_snap)
            2'd1:    r_ext = abs_ext;
            2'd2:    r_ext = x_ext + OFF_EXT;
            default: r_ext = abs_ext + OFF_EXT;  // mode 3 is reserved, acts as mode 0
        endcase
        if (r_ext > MAX_EXT) begin
            ch_res = MAX_OUT;
            ch_sat = 1'b1;
        end else begin
            ch_res = r_ext[WIDTH-1:0];
            ch_sat = 1'b0;
        end
    end

    // Working buffer with the current channel's result merged in; on the last
    // channel this is what loads denom/sat so every channel updates together.
    always_comb begin
        work_nxt     = work_buf;
        work_sat_nxt = work_sat;
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx == IDX_W'(i)) begin
                work_nxt[i*WIDTH +: WIDTH] = ch_res;
                work_sat_nxt[i]            = ch_sat;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CALC;
            S_CALC:  if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Snapshot, channel sequencing and registered outputs.
    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            idx       <= '0;
            x_snap    <= '0;
            mode_snap <= '0;
            work_buf  <= '0;
            work_sat  <= '0;
            denom     <= '0;
            sat       <= '0;
            busy      <= 1'b0;
            startout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_snap    <= X;
                        mode_snap <= mode;
                        idx       <= '0;
                        busy      <= 1'b1;
                    end
                end
                S_CALC: begin
                    work_buf <= work_nxt;
                    work_sat <= work_sat_nxt;
                    if (last) begin
                        denom    <= work_nxt;
                        sat      <= work_sat_nxt;
                        startout <= 1'b1;
                        idx      <= '0;
                    end else begin
                        idx <= idx + IDX_ONE;
                    end
                end
                S_DONE: begin
                    startout <= 1'b0;
                    busy     <= 1'b0;
                end
                default: begin
                    startout <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softsign_denom_array.sv
// Bench for softsign_denom_array (WIDTH=32, CHANNELS=4, OFFSET=1).
module tb_softsign_denom_array;

    localparam int W  = 32;
    localparam int CH = 4;

    logic              CLOCK;
    logic              reset;
    logic              start;
    logic [1:0]        mode;
    logic [CH*W-1:0]   X;
    logic [CH*W-1:0]   denom;
    logic [CH-1:0]     sat;
    logic              busy;
    logic              startout;

    typedef struct {
        logic [CH*W-1:0] d;
        logic [CH-1:0]   s;
    } exp_t;

    exp_t sb[$];
    int   done_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    logic so_prev = 1'b0;

    softsign_denom_array #(.WIDTH(W), .CHANNELS(CH), .OFFSET(1)) dut (
        .CLOCK(CLOCK), .reset(reset), .start(start), .mode(mode), .X(X),
        .denom(denom), .sat(sat), .busy(busy), .startout(startout)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    always @(posedge CLOCK) cyc++;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [CH*W-1:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    // Reference: 64-bit arithmetic, clamp at 2^31-1.
    function automatic exp_t model(input logic [CH*W-1:0] x, input logic [1:0] m);
        exp_t   e;
        longint v;
        longint a;
        longint r;
        for (int i = 0; i < CH; i++) begin
            v = longint'($signed(x[i*W +: W]));
            a = (v < 0) ? -v : v;
            case (m)
                2'd1:    r = a;
                2'd2:    r = v + 1;
                default: r = a + 1;
            endcase
            if (r > 64'sd2147483647) begin
                e.d[i*W +: W] = 32'h7FFFFFFF;
                e.s[i]        = 1'b1;
            end else begin
                e.d[i*W +: W] = r[31:0];
                e.s[i]        = 1'b0;
            end
        end
        return e;
    endfunction

    // Scoreboard consumer: every startout pops one expected result.
    always @(negedge CLOCK) begin
        exp_t e;
        if (reset && startout) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            chk("done_pulse_width", 128'(so_prev), 128'(0));
            if (sb.size() == 0) begin
                chk("spurious_done", 128'(1), 128'(0));
            end else begin
                e = sb.pop_front();
                chk("sb_denom", 128'(denom), 128'(e.d));
                chk("sb_sat", 128'(sat), 128'(e.s));
            end
        end
        so_prev = startout;
    end

    task automatic run_txn(input logic [CH*W-1:0] x, input logic [1:0] m);
        @(negedge CLOCK);
        X     = x;
        mode  = m;
        start = 1'b1;
        sb.push_back(model(x, m));
        @(negedge CLOCK);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < maxc) begin
            @(negedge CLOCK);
            n++;
        end
        chk("idle_timeout", 128'(n < maxc), 128'(1));
    endtask

    initial begin
        logic [CH*W-1:0] s1, s2, s3a, s3b, xa, xb;
        int d0;

        s1  = pack4(5, -5, 0, -1);
        s2  = pack4(32'h80000000, 32'h7FFFFFFF, -2, 3);
        s3a = pack4(-7, 7, 32'h80000000, 0);
        s3b = pack4(-3, 32'h7FFFFFFF, -1, 10);
        xa  = pack4(100, -200, 32'h80000000, 32'h7FFFFFFE);
        xb  = pack4(-9, 12, -1, 32'h80000001);

        reset = 1'b0;
        start = 1'b0;
        mode  = 2'd0;
        X     = '0;
        #3;
        chk("rst_denom", 128'(denom), 128'(0));
        chk("rst_sat", 128'(sat), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_startout", 128'(startout), 128'(0));
        @(negedge CLOCK);
        reset = 1'b1;
        repeat (2) @(negedge CLOCK);

        // Scenario 1 with cycle-exact busy/startout timing.
        X     = s1;
        mode  = 2'd0;
        start = 1'b1;
        sb.push_back(model(s1, 2'd0));
        @(negedge CLOCK);
        start = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (j > 0) @(negedge CLOCK);
            chk("s1_busy", 128'(busy), 128'(j < 5));
            chk("s1_startout", 128'(startout), 128'(j == 4));
        end
        chk("s1_denom", 128'(denom), 128'(pack4(6, 6, 1, 2)));
        chk("s1_sat", 128'(sat), 128'(4'b0000));

        // Hold through idle, then switch atomically on scenario 2's DONE edge.
        repeat (10) @(negedge CLOCK);
        chk("hold_idle_denom", 128'(denom), 128'(pack4(6, 6, 1, 2)));
        chk("hold_idle_sat", 128'(sat), 128'(4'b0000));
        X     = s2;
        start = 1'b1;
        sb.push_back(model(s2, 2'd0));
        @(negedge CLOCK);
        start = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge CLOCK);
            if (j < 4) begin
                chk("hold_calc_denom", 128'(denom), 128'(pack4(6, 6, 1, 2)));
            end else begin
                chk("s2_denom", 128'(denom),
                    128'(pack4(32'h7FFFFFFF, 32'h7FFFFFFF, 3, 4)));
                chk("s2_sat", 128'(sat), 128'(4'b0011));
            end
        end
        wait_idle(20);

        // Scenario 3: modes 1 and 2, plus reserved mode 3.
        run_txn(s3a, 2'd1);
        wait_idle(20);
        chk("m1_denom", 128'(denom), 128'(pack4(7, 7, 32'h7FFFFFFF, 0)));
        chk("m1_sat", 128'(sat), 128'(4'b0100));
        run_txn(s3b, 2'd2);
        wait_idle(20);
        chk("m2_denom", 128'(denom), 128'(pack4(32'hFFFFFFFE, 32'h7FFFFFFF, 0, 11)));
        chk("m2_sat", 128'(sat), 128'(4'b0010));
        run_txn(s2, 2'd3);
        wait_idle(20);
        chk("m3_sat", 128'(sat), 128'(4'b0011));

        // Scenario 4a: input churn and start pulses while busy.
        d0 = done_cnt;
        @(negedge CLOCK);
        X     = xa;
        mode  = 2'd0;
        start = 1'b1;
        sb.push_back(model(xa, 2'd0));
        for (int j = 0; j < 5; j++) begin
            @(negedge CLOCK);
            X     = {$urandom, $urandom, $urandom, $urandom};
            mode  = 2'($urandom_range(0, 3));
            start = 1'b1;
        end
        @(negedge CLOCK);
        start = 1'b0;
        wait_idle(20);
        repeat (3) @(negedge CLOCK);
        chk("snap_single_done", 128'(done_cnt - d0), 128'(1));

        // Scenario 4b: start held high -> one transaction every 6 cycles.
        d0 = done_cnt;
        done_cyc.delete();
        @(negedge CLOCK);
        X     = xb;
        mode  = 2'd1;
        start = 1'b1;
        repeat (3) sb.push_back(model(xb, 2'd1));
        repeat (13) @(negedge CLOCK);
        start = 1'b0;
        wait_idle(40);
        chk("burst_count", 128'(done_cnt - d0), 128'(3));
        if (done_cyc.size() >= 3) begin
            chk("burst_period_a", 128'(done_cyc[1] - done_cyc[0]), 128'(6));
            chk("burst_period_b", 128'(done_cyc[2] - done_cyc[1]), 128'(6));
        end else begin
            chk("burst_pulses", 128'(done_cyc.size()), 128'(3));
        end

        // Scenario 5: asynchronous reset two cycles into CALC.
        run_txn(s1, 2'd0);
        repeat (2) @(negedge CLOCK);
        reset = 1'b0;
        #1;
        chk("abort_denom", 128'(denom), 128'(0));
        chk("abort_sat", 128'(sat), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_startout", 128'(startout), 128'(0));
        void'(sb.pop_back());
        d0 = done_cnt;
        repeat (3) @(negedge CLOCK);
        reset = 1'b1;
        repeat (8) @(negedge CLOCK);
        chk("abort_no_done", 128'(done_cnt - d0), 128'(0));
        run_txn(s1, 2'd0);
        wait_idle(20);
        chk("post_reset_denom", 128'(denom), 128'(pack4(6, 6, 1, 2)));
        chk("post_reset_sat", 128'(sat), 128'(4'b0000));
        chk("sb_empty", 128'(sb.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
